// File: rtl/octal_counter_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : octal_counter_ctrl
// Description : Two-digit octal up-counter (00..77) advanced by a clock
//               prescaler. Two debounced active-low keys: pause toggles
//               RUN/PAUSE, clear zeroes the digits and the prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
module octal_counter_ctrl #(
   parameter int TICK_DIV = 12000000,
   parameter int DEB_CYC  = 240000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_pause_n,
   input  logic       key_clr_n,
   output logic [2:0] seg_data_1,
   output logic [2:0] seg_data_2,
   output logic       run,
   output logic       tick,
   output logic       wrap
);

   localparam int c_presc_w = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int c_deb_w   = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;

   localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(TICK_DIV - 1);
   localparam logic [c_presc_w-1:0] c_presc_one = c_presc_w'(1);
   localparam logic [c_deb_w-1:0]   c_deb_max   = c_deb_w'(DEB_CYC - 1);
   localparam logic [c_deb_w-1:0]   c_deb_one   = c_deb_w'(1);

   // State encoding doubles as the run output: RUN is the 1 value
   localparam logic [0:0] S_PAUSE = 1'b0;
   localparam logic [0:0] S_RUN   = 1'b1;

   // Bit 0 = pause key, bit 1 = clear key
   logic [1:0] w_key_raw;
   logic [1:0] w_press;

   assign w_key_raw = {key_clr_n, key_pause_n};

   // Per-key synchronizer, debounce filter and press detector
   for (genvar gi = 0; gi < 2; gi++) begin : g_key
      logic [1:0]         r_sync;
      logic               r_stable;
      logic [c_deb_w-1:0] r_cnt;
      logic               w_level;

      assign w_level = r_sync[1];

      // Press fires in the cycle the stable level is about to fall, so the
      // consumers act on the same edge the stable level updates
      assign w_press[gi] = (r_cnt == c_deb_max) && (w_level != r_stable) && !w_level;

      // Two-flop synchronizer into the clk domain
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_sync <= 2'b11;
         end else begin
            r_sync <= {r_sync[0], w_key_raw[gi]};
         end
      end

      // Accept a new level only after it has differed for DEB_CYC cycles
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_stable <= 1'b1;
            r_cnt    <= '0;
         end else if (w_level == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == c_deb_max) begin
            r_stable <= w_level;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + c_deb_one;
         end
      end
   end

   logic                 w_pause_press;
   logic                 w_clr_press;
   logic [0:0]           r_state;
   logic [c_presc_w-1:0] r_presc;
   logic [2:0]           r_dig_hi;
   logic [2:0]           r_dig_lo;
   logic                 r_tick;
   logic                 r_wrap;
   logic                 w_step;
   logic                 w_at_max;

   assign w_pause_press = w_press[0];
   assign w_clr_press   = w_press[1];
   assign w_step        = (r_state == S_RUN) && (r_presc == c_presc_max);
   assign w_at_max      = (r_dig_hi == 3'd7) && (r_dig_lo == 3'd7);

   // RUN/PAUSE toggle on each pause press; a coinciding step still completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_RUN;
      end else if (w_pause_press) begin
         r_state <= (r_state == S_RUN) ? S_PAUSE : S_RUN;
      end
   end

   // Prescaler, digit counter and one-cycle tick/wrap pulses; clear wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc  <= '0;
         r_dig_hi <= 3'd0;
         r_dig_lo <= 3'd0;
         r_tick   <= 1'b0;
         r_wrap   <= 1'b0;
      end else if (w_clr_press) begin
         r_presc  <= '0;
         r_dig_hi <= 3'd0;
         r_dig_lo <= 3'd0;
         r_tick   <= 1'b0;
         r_wrap   <= 1'b0;
      end else begin
         r_tick <= w_step;
         r_wrap <= w_step && w_at_max;
         if (r_state == S_RUN) begin
            r_presc <= w_step ? '0 : (r_presc + c_presc_one);
         end
         if (w_step) begin
            if (r_dig_lo == 3'd7) begin
               r_dig_lo <= 3'd0;
               r_dig_hi <= r_dig_hi + 3'd1;
            end else begin
               r_dig_lo <= r_dig_lo + 3'd1;
            end
         end
      end
   end

   assign seg_data_1 = r_dig_hi;
   assign seg_data_2 = r_dig_lo;
   assign run        = r_state[0];
   assign tick       = r_tick;
   assign wrap       = r_wrap;

endmodule
`default_nettype wire
